// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU codes and the
// ID/EX control bundle layout.
package mips_pkg;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   localparam logic [5:0] FnSll = 6'b000000;
   localparam logic [5:0] FnSrl = 6'b000010;
   localparam logic [5:0] FnSra = 6'b000011;
   localparam logic [5:0] FnJr  = 6'b001000;
   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnXor = 6'b100110;
   localparam logic [5:0] FnNor = 6'b100111;
   localparam logic [5:0] FnSlt = 6'b101010;

   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluXor = 4'b0011;
   localparam logic [3:0] AluSll = 4'b0100;
   localparam logic [3:0] AluSrl = 4'b0101;
   localparam logic [3:0] AluSub = 4'b0110;
   localparam logic [3:0] AluSlt = 4'b0111;
   localparam logic [3:0] AluSra = 4'b1000;
   localparam logic [3:0] AluLui = 4'b1001;
   localparam logic [3:0] AluNor = 4'b1100;

   localparam logic [4:0] LinkReg = 5'd31;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       use_shamt;
      logic       branch_eq;
      logic       branch_ne;
      logic       jump;
      logic       jump_reg;
      logic       link;
      logic       zero_ext;
      logic [3:0] alu_op;
   } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder: instruction word to control bundle,
// destination register, illegal flag and rt-usage flag.
module ctrl_decode
   import mips_pkg::*;
#(
   parameter int unsigned EXT_ISA = 1
) (
   input  logic [31:0]  instr_i,
   output ctrl_bundle_t ctrl_o,
   output logic [4:0]   wr_addr_o,
   output logic         illegal_o,
   output logic         uses_rt_o
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       ext_en;
   logic       unused_shamt;

   assign opcode       = instr_i[31:26];
   assign funct        = instr_i[5:0];
   assign rt           = instr_i[20:16];
   assign rd           = instr_i[15:11];
   assign ext_en       = (EXT_ISA != 0);
   assign unused_shamt = ^instr_i[10:6];

   always_comb begin
      ctrl_o    = '0;
      wr_addr_o = '0;
      illegal_o = 1'b0;
      uses_rt_o = 1'b0;
      case (opcode)
         OpRtype: begin
            ctrl_o.reg_write = 1'b1;
            wr_addr_o        = rd;
            uses_rt_o        = 1'b1;
            case (funct)
               FnAdd: ctrl_o.alu_op = AluAdd;
               FnSub: ctrl_o.alu_op = AluSub;
               FnAnd: ctrl_o.alu_op = AluAnd;
               FnOr:  ctrl_o.alu_op = AluOr;
               FnXor: ctrl_o.alu_op = AluXor;
               FnNor: ctrl_o.alu_op = AluNor;
               FnSlt: ctrl_o.alu_op = AluSlt;
               FnSll: begin
                  ctrl_o.alu_op    = AluSll;
                  ctrl_o.use_shamt = 1'b1;
               end
               FnSrl: begin
                  ctrl_o.alu_op    = AluSrl;
                  ctrl_o.use_shamt = 1'b1;
               end
               FnSra: begin
                  ctrl_o.alu_op    = AluSra;
                  ctrl_o.use_shamt = 1'b1;
                  illegal_o        = ~ext_en;
               end
               FnJr: begin
                  ctrl_o.reg_write = 1'b0;
                  ctrl_o.jump_reg  = 1'b1;
                  wr_addr_o        = '0;
                  uses_rt_o        = 1'b0;
                  illegal_o        = ~ext_en;
               end
               default: illegal_o = 1'b1;
            endcase
         end
         OpLw: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.alu_op     = AluAdd;
            wr_addr_o         = rt;
         end
         OpSw: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = AluAdd;
            uses_rt_o        = 1'b1;
         end
         OpBeq: begin
            ctrl_o.branch_eq = 1'b1;
            ctrl_o.alu_op    = AluSub;
            uses_rt_o        = 1'b1;
         end
         OpBne: begin
            ctrl_o.branch_ne = 1'b1;
            ctrl_o.alu_op    = AluSub;
            uses_rt_o        = 1'b1;
            illegal_o        = ~ext_en;
         end
         OpJ: ctrl_o.jump = 1'b1;
         OpJal: begin
            ctrl_o.jump      = 1'b1;
            ctrl_o.link      = 1'b1;
            ctrl_o.reg_write = 1'b1;
            wr_addr_o        = LinkReg;
            illegal_o        = ~ext_en;
         end
         OpAddi: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = AluAdd;
            wr_addr_o        = rt;
         end
         OpSlti: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = AluSlt;
            wr_addr_o        = rt;
            illegal_o        = ~ext_en;
         end
         OpAndi, OpOri, OpLui: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.zero_ext  = 1'b1;
            ctrl_o.alu_op    = (opcode == OpAndi) ? AluAnd :
                               (opcode == OpOri)  ? AluOr  : AluLui;
            wr_addr_o        = rt;
            illegal_o        = ~ext_en;
         end
         default: illegal_o = 1'b1;
      endcase

      // Unknown encodings must not leak partial controls into EX.
      if (illegal_o) begin
         ctrl_o    = '0;
         wr_addr_o = '0;
         uses_rt_o = 1'b0;
      end
   end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID stage decode plus ID/EX control register with flush/stall/bubble handling
// and load-use hazard detection.
module ctrl_decode_pipe
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALU_CTRL_W = 4,
   parameter int unsigned EXT_ISA    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [31:0]           id_instr,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  hazard_stall,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_mem_to_reg,
   output logic                  ex_alu_src,
   output logic                  ex_use_shamt,
   output logic                  ex_branch_eq,
   output logic                  ex_branch_ne,
   output logic                  ex_jump,
   output logic                  ex_jump_reg,
   output logic                  ex_link,
   output logic                  ex_zero_ext,
   output logic [ALU_CTRL_W-1:0] ex_alu_control,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_wr_addr,
   output logic                  ex_illegal
);

   ctrl_bundle_t            dec_ctrl;
   logic [4:0]              dec_wr;
   logic                    dec_illegal;
   logic                    dec_uses_rt;
   logic [REG_ADDR_W-1:0]   id_rs;
   logic [REG_ADDR_W-1:0]   id_rt;

   ctrl_bundle_t            ctrl_d, ctrl_q;
   logic                    valid_d, valid_q;
   logic                    illegal_d, illegal_q;
   logic [REG_ADDR_W-1:0]   rs_d, rs_q;
   logic [REG_ADDR_W-1:0]   rt_d, rt_q;
   logic [REG_ADDR_W-1:0]   wr_d, wr_q;

   ctrl_decode #(
      .EXT_ISA (EXT_ISA)
   ) u_decode (
      .instr_i   (id_instr),
      .ctrl_o    (dec_ctrl),
      .wr_addr_o (dec_wr),
      .illegal_o (dec_illegal),
      .uses_rt_o (dec_uses_rt)
   );

   assign id_rs = REG_ADDR_W'(id_instr[25:21]);
   assign id_rt = REG_ADDR_W'(id_instr[20:16]);

   assign hazard_stall = ~flush & id_valid & valid_q & ctrl_q.mem_read & (wr_q != '0) &
                         ((wr_q == id_rs) | (dec_uses_rt & (wr_q == id_rt)));

   always_comb begin
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      wr_d      = wr_q;
      // Flush beats stall; an empty slot or load-use hazard inserts a bubble.
      if (flush || (!stall && (hazard_stall || !id_valid))) begin
         ctrl_d    = '0;
         valid_d   = 1'b0;
         illegal_d = 1'b0;
         rs_d      = '0;
         rt_d      = '0;
         wr_d      = '0;
      end else if (!stall) begin
         ctrl_d    = dec_ctrl;
         valid_d   = 1'b1;
         illegal_d = dec_illegal;
         rs_d      = dec_illegal ? '0 : id_rs;
         rt_d      = dec_illegal ? '0 : id_rt;
         wr_d      = REG_ADDR_W'(dec_wr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         rs_q      <= '0;
         rt_q      <= '0;
         wr_q      <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         wr_q      <= wr_d;
      end
   end

   assign ex_valid       = valid_q;
   assign ex_illegal     = illegal_q;
   assign ex_reg_write   = ctrl_q.reg_write;
   assign ex_mem_read    = ctrl_q.mem_read;
   assign ex_mem_write   = ctrl_q.mem_write;
   assign ex_mem_to_reg  = ctrl_q.mem_to_reg;
   assign ex_alu_src     = ctrl_q.alu_src;
   assign ex_use_shamt   = ctrl_q.use_shamt;
   assign ex_branch_eq   = ctrl_q.branch_eq;
   assign ex_branch_ne   = ctrl_q.branch_ne;
   assign ex_jump        = ctrl_q.jump;
   assign ex_jump_reg    = ctrl_q.jump_reg;
   assign ex_link        = ctrl_q.link;
   assign ex_zero_ext    = ctrl_q.zero_ext;
   assign ex_alu_control = ALU_CTRL_W'(ctrl_q.alu_op);
   assign ex_rs          = rs_q;
   assign ex_rt          = rt_q;
   assign ex_wr_addr     = wr_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed steps then random traffic, checked
// against a mnemonic-level model for both the extended and base ISA builds.
module tb_ctrl_decode_pipe;

   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic       rw;
      logic       mr;
      logic       mw;
      logic       m2r;
      logic       asrc;
      logic       shamt;
      logic       beq;
      logic       bne;
      logic       j;
      logic       jr;
      logic       link;
      logic       zext;
      logic [3:0] alu;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wr;
   } exp_t;

   logic        clk, rst, id_valid, stall, flush;
   logic [31:0] id_instr;

   logic       hz1, val1, rw1, mr1, mw1, m2r1, src1, sh1, beq1, bne1, j1, jr1, lnk1, zx1, ill1;
   logic [3:0] alu1;
   logic [4:0] rs1, rt1, wr1;
   logic       hz0, val0, rw0, mr0, mw0, m2r0, src0, sh0, beq0, bne0, j0, jr0, lnk0, zx0, ill0;
   logic [3:0] alu0;
   logic [4:0] rs0, rt0, wr0;

   exp_t g1, g0, m1, m0;
   int   total = 0;
   int   bad   = 0;

   ctrl_decode_pipe #(.REG_ADDR_W(5), .ALU_CTRL_W(4), .EXT_ISA(1)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .stall(stall),
      .flush(flush), .hazard_stall(hz1), .ex_valid(val1), .ex_reg_write(rw1),
      .ex_mem_read(mr1), .ex_mem_write(mw1), .ex_mem_to_reg(m2r1), .ex_alu_src(src1),
      .ex_use_shamt(sh1), .ex_branch_eq(beq1), .ex_branch_ne(bne1), .ex_jump(j1),
      .ex_jump_reg(jr1), .ex_link(lnk1), .ex_zero_ext(zx1), .ex_alu_control(alu1),
      .ex_rs(rs1), .ex_rt(rt1), .ex_wr_addr(wr1), .ex_illegal(ill1)
   );

   ctrl_decode_pipe #(.REG_ADDR_W(5), .ALU_CTRL_W(4), .EXT_ISA(0)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .stall(stall),
      .flush(flush), .hazard_stall(hz0), .ex_valid(val0), .ex_reg_write(rw0),
      .ex_mem_read(mr0), .ex_mem_write(mw0), .ex_mem_to_reg(m2r0), .ex_alu_src(src0),
      .ex_use_shamt(sh0), .ex_branch_eq(beq0), .ex_branch_ne(bne0), .ex_jump(j0),
      .ex_jump_reg(jr0), .ex_link(lnk0), .ex_zero_ext(zx0), .ex_alu_control(alu0),
      .ex_rs(rs0), .ex_rt(rt0), .ex_wr_addr(wr0), .ex_illegal(ill0)
   );

   always_comb begin
      g1 = '0;
      g1 = '{val1, ill1, rw1, mr1, mw1, m2r1, src1, sh1, beq1, bne1, j1, jr1, lnk1, zx1,
             alu1, rs1, rt1, wr1};
      g0 = '0;
      g0 = '{val0, ill0, rw0, mr0, mw0, m2r0, src0, sh0, beq0, bne0, j0, jr0, lnk0, zx0,
             alu0, rs0, rt0, wr0};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [31:0] r_ins(int fn, int rs, int rt, int rd, int sh);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   // Mnemonic of an instruction, or "" if the build does not accept it.
   function automatic string mnem(logic [31:0] ins, bit ext);
      int op, fn;
      string m;
      op = int'(ins[31:26]);
      fn = int'(ins[5:0]);
      m  = "";
      case (op)
         0: case (fn)
               32: m = "add";  34: m = "sub";  36: m = "and";  37: m = "or";
               38: m = "xor";  39: m = "nor";  42: m = "slt";  0:  m = "sll";
               2:  m = "srl";  3:  m = "sra";  8:  m = "jr";
               default: m = "";
            endcase
         35: m = "lw";   43: m = "sw";   4: m = "beq";  5: m = "bne";
         2:  m = "j";    3:  m = "jal";  8: m = "addi"; 12: m = "andi";
         13: m = "ori";  10: m = "slti"; 15: m = "lui";
         default: m = "";
      endcase
      if (!ext && (m == "sra" || m == "jr" || m == "bne" || m == "jal" || m == "andi" ||
                   m == "ori" || m == "slti" || m == "lui")) m = "";
      return m;
   endfunction

   function automatic bit uses_rt(logic [31:0] ins, bit ext);
      string m;
      m = mnem(ins, ext);
      case (m)
         "add", "sub", "and", "or", "xor", "nor", "slt", "sll", "srl", "sra",
         "beq", "bne", "sw": return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t dec(bit v, logic [31:0] ins, bit ext);
      exp_t  e;
      string m;
      e = '0;
      if (!v) return e;
      e.valid = 1'b1;
      m = mnem(ins, ext);
      if (m == "") begin
         e.illegal = 1'b1;
         return e;
      end
      e.rs = ins[25:21];
      e.rt = ins[20:16];
      case (m)
         "and", "andi": e.alu = 4'd0;
         "or", "ori": e.alu = 4'd1;
         "add", "lw", "sw", "addi": e.alu = 4'd2;
         "xor": e.alu = 4'd3;
         "sll": e.alu = 4'd4;
         "srl": e.alu = 4'd5;
         "sub", "beq", "bne": e.alu = 4'd6;
         "slt", "slti": e.alu = 4'd7;
         "sra": e.alu = 4'd8;
         "lui": e.alu = 4'd9;
         "nor": e.alu = 4'd12;
         default: e.alu = 4'd0;
      endcase
      case (m)
         "add", "sub", "and", "or", "xor", "nor", "slt", "sll", "srl", "sra": begin
            e.rw = 1'b1;
            e.wr = ins[15:11];
         end
         "lw", "addi", "andi", "ori", "slti", "lui": begin
            e.rw = 1'b1;
            e.wr = ins[20:16];
         end
         "jal": begin
            e.rw = 1'b1;
            e.wr = 5'd31;
         end
         default: e.wr = 5'd0;
      endcase
      e.mr    = (m == "lw");
      e.m2r   = (m == "lw");
      e.mw    = (m == "sw");
      e.asrc  = (m == "lw" || m == "sw" || m == "addi" || m == "andi" || m == "ori" ||
                 m == "slti" || m == "lui");
      e.zext  = (m == "andi" || m == "ori" || m == "lui");
      e.shamt = (m == "sll" || m == "srl" || m == "sra");
      e.beq   = (m == "beq");
      e.bne   = (m == "bne");
      e.j     = (m == "j" || m == "jal");
      e.link  = (m == "jal");
      e.jr    = (m == "jr");
      return e;
   endfunction

   function automatic bit hz_model(exp_t cur, bit ext);
      return !flush && id_valid && cur.valid && cur.mr && (cur.wr != 0) &&
             ((cur.wr == id_instr[25:21]) ||
              (uses_rt(id_instr, ext) && cur.wr == id_instr[20:16]));
   endfunction

   function automatic exp_t next_model(exp_t cur, bit ext, bit h);
      if (flush) return '0;
      if (stall) return cur;
      if (h) return '0;
      return dec(id_valid, id_instr, ext);
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one ID slot, check hazard before the edge and ID/EX after it.
   task automatic step(input bit v, input logic [31:0] ins, input bit st, input bit fl,
                       input int exp_h);
      bit h1, h0;
      id_valid = v;
      id_instr = ins;
      stall    = st;
      flush    = fl;
      #1;
      h1 = hz_model(m1, 1'b1);
      h0 = hz_model(m0, 1'b0);
      chk("hazard_ext", 64'(hz1), 64'(h1));
      chk("hazard_base", 64'(hz0), 64'(h0));
      if (exp_h >= 0) chk("hazard_directed", 64'(hz1), 64'(exp_h));
      @(posedge clk);
      m1 = next_model(m1, 1'b1, h1);
      m0 = next_model(m0, 1'b0, h0);
      #1;
      chk("idex_ext", 64'(g1), 64'(m1));
      chk("idex_base", 64'(g0), 64'(m0));
   endtask

   initial begin
      logic [31:0] add3, lw5, add6, rins;
      int          ops[16];
      int          fns[11];
      rst      = 1'b1;
      id_valid = 1'b0;
      id_instr = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      m1       = '0;
      m0       = '0;
      ops = '{0, 0, 0, 35, 35, 43, 4, 5, 2, 3, 8, 12, 13, 10, 15, 63};
      fns = '{32, 34, 36, 37, 38, 39, 42, 0, 2, 3, 8};
      add3 = r_ins(32, 1, 2, 3, 0);
      lw5  = i_ins(35, 1, 5, 0);
      add6 = r_ins(32, 2, 5, 6, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ext", 64'(g1), 64'd0);
      chk("reset_base", 64'(g0), 64'd0);
      chk("reset_hazard", 64'(hz1), 64'd0);
      rst = 1'b0;

      step(1'b1, add3, 1'b0, 1'b0, 0);
      chk("add_valid", 64'(val1), 64'd1);
      chk("add_rw", 64'(rw1), 64'd1);
      chk("add_alu", 64'(alu1), 64'h2);
      chk("add_wr_rs_rt", 64'({wr1, rs1, rt1}), 64'({5'd3, 5'd1, 5'd2}));

      // Load-use: exactly one bubble.
      step(1'b1, lw5, 1'b0, 1'b0, 0);
      step(1'b1, add6, 1'b0, 1'b0, 1);
      chk("lu_bubble", 64'(val1), 64'd0);
      step(1'b1, add6, 1'b0, 1'b0, 0);
      chk("lu_add_rt", 64'({val1, rt1, wr1}), 64'({1'b1, 5'd5, 5'd6}));

      // Load-use under external stall: load held, then one bubble.
      step(1'b1, lw5, 1'b0, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, add6, 1'b1, 1'b0, 1);
         chk("stall_hold_lw", 64'({val1, mr1, wr1}), 64'({1'b1, 1'b1, 5'd5}));
      end
      step(1'b1, add6, 1'b0, 1'b0, 1);
      chk("stall_bubble", 64'(val1), 64'd0);
      step(1'b1, add6, 1'b0, 1'b0, 0);
      chk("stall_add", 64'({val1, rt1}), 64'({1'b1, 5'd5}));

      // Extended ops.
      step(1'b1, i_ins(3, 0, 0, 16'h0040), 1'b0, 1'b0, 0);
      chk("jal", 64'({lnk1, j1, rw1, wr1}), 64'({3'b111, 5'd31}));
      step(1'b1, i_ins(15, 0, 4, 16'h1234), 1'b0, 1'b0, 0);
      chk("lui", 64'({zx1, alu1, wr1}), 64'({1'b1, 4'h9, 5'd4}));
      step(1'b1, r_ins(3, 0, 2, 7, 4), 1'b0, 1'b0, 0);
      chk("sra", 64'({sh1, alu1, wr1}), 64'({1'b1, 4'h8, 5'd7}));

      // Illegal encodings.
      step(1'b1, i_ins(5, 1, 2, 16'h0008), 1'b0, 1'b0, 0);
      chk("bne_base_illegal", 64'({val0, ill0}), 64'd3);
      chk("bne_base_ctrls", 64'(g0) & 64'h0_FFFF_FFFF >> 2, 64'd0);
      step(1'b1, {6'b111111, 26'h155_5555}, 1'b0, 1'b0, 0);
      chk("op63_illegal", 64'({val1, ill1}), 64'd3);
      chk("op63_ctrls", 64'({rw1, mr1, mw1, m2r1, src1, sh1, beq1, bne1, j1, jr1, lnk1, zx1,
                             alu1, wr1}), 64'd0);

      // Flush beats stall and hazard.
      step(1'b1, lw5, 1'b0, 1'b0, 0);
      step(1'b1, add6, 1'b1, 1'b1, 0);
      chk("flush_bubble", 64'({val1, mr1, wr1}), 64'd0);

      // Asynchronous reset between edges.
      step(1'b1, add3, 1'b0, 1'b0, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ext", 64'(g1), 64'd0);
      chk("async_rst_base", 64'(g0), 64'd0);
      chk("async_rst_hazard", 64'(hz1), 64'd0);
      rst = 1'b0;
      m1 = '0;
      m0 = '0;
      step(1'b1, add3, 1'b0, 1'b0, 0);
      chk("post_rst_load", 64'({val1, wr1}), 64'({1'b1, 5'd3}));

      // Random traffic with small register numbers to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         rins = {6'(ops[$urandom_range(0, 15)]), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                 6'(($urandom_range(0, 9) == 0) ? $urandom : fns[$urandom_range(0, 10)])};
         step($urandom_range(0, 9) != 0, rins, $urandom_range(0, 6) == 0,
              $urandom_range(0, 9) == 0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
